// File: rtl/exec_control_unit_if.sv
// Bundle between the issue/control stage and its neighbours: instruction handshake,
// decoded ALU fields, NZCV flags in both directions and writeback strobes.
interface exec_control_unit_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic        cu_execute;
    logic [4:0]  alu_op;
    logic [3:0]  rn_addr;
    logic [3:0]  rm_addr;
    logic [3:0]  rd_addr;
    logic [3:0]  rs_addr;
    logic        imm_en;
    logic        s_en;
    logic        br_l;
    logic [1:0]  stype;
    logic [4:0]  imm_shift;
    logic [11:0] imm_operand;
    logic [23:0] br_offset_imm;
    logic        flag_n;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;
    logic        alu_n;
    logic        alu_z;
    logic        alu_c;
    logic        alu_v;
    logic        rd_we;
    logic        pc_we;
    logic        cond_skip;
    logic        undef;
    logic [1:0]  dbg_state;

    // The control unit itself.
    modport slave (
        input  instr_valid, instr_word, alu_n, alu_z, alu_c, alu_v,
        output instr_ready, cu_execute, alu_op, rn_addr, rm_addr, rd_addr, rs_addr,
               imm_en, s_en, br_l, stype, imm_shift, imm_operand, br_offset_imm,
               flag_n, flag_z, flag_c, flag_v, rd_we, pc_we, cond_skip, undef, dbg_state
    );

    // Instruction source plus ALU side.
    modport master (
        output instr_valid, instr_word, alu_n, alu_z, alu_c, alu_v,
        input  instr_ready, cu_execute, alu_op, rn_addr, rm_addr, rd_addr, rs_addr,
               imm_en, s_en, br_l, stype, imm_shift, imm_operand, br_offset_imm,
               flag_n, flag_z, flag_c, flag_v, rd_we, pc_we, cond_skip, undef, dbg_state
    );
endinterface

// File: rtl/exec_control_unit.sv
// Non-pipelined issue/control stage ahead of the ALU: accepts one ARM instruction, decodes it,
// checks its condition against the owned NZCV register, strobes execute and then writeback.
module exec_control_unit #(
    parameter logic [3:0] FLAG_RST   = 4'b0000,
    parameter logic [4:0] UNDEF_CODE = 5'h1F,
    // Operation encodings shared with the ALU's Defines.v.
    parameter logic [4:0] OP_MOV_LAS = 5'h0D,
    parameter logic [4:0] OP_ADD     = 5'h04,
    parameter logic [4:0] OP_ADC     = 5'h05,
    parameter logic [4:0] OP_B       = 5'h10,
    parameter logic [4:0] OP_BX      = 5'h11,
    parameter logic [4:0] OP_ERET    = 5'h12
) (
    input logic           clk,
    input logic           rst,
    exec_control_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q;
    logic [3:0]  nzcv_q;
    logic [4:0]  op_q;
    logic [3:0]  rn_q, rm_q, rd_q, rs_q;
    logic        imm_en_q, s_en_q, br_l_q;
    logic [1:0]  stype_q;
    logic [4:0]  imm_shift_q;
    logic [11:0] imm_operand_q;
    logic [23:0] br_offset_q;

    logic [4:0]  dec_op;
    logic        dec_undef;
    logic        cond_ok;
    logic        wb_is_alu;

    // Decode of the latched word, first match wins in the listed order.
    always_comb begin
        dec_op    = UNDEF_CODE;
        dec_undef = 1'b1;
        if (instr_q[27:4] == 24'h12FFF1) begin
            dec_op    = OP_BX;
            dec_undef = 1'b0;
        end else if (instr_q[27:0] == 28'h160006E) begin
            dec_op    = OP_ERET;
            dec_undef = 1'b0;
        end else if (instr_q[27:25] == 3'b101) begin
            dec_op    = OP_B;
            dec_undef = 1'b0;
        end else if (instr_q[27:26] == 2'b00) begin
            case (instr_q[24:21])
                4'b1101: begin dec_op = OP_MOV_LAS; dec_undef = 1'b0; end
                4'b0100: begin dec_op = OP_ADD;     dec_undef = 1'b0; end
                4'b0101: begin dec_op = OP_ADC;     dec_undef = 1'b0; end
                default: ;
            endcase
        end
    end

    always_comb begin
        cond_ok = 1'b1;
        case (instr_q[31:28])
            4'h0: cond_ok = nzcv_q[2];
            4'h1: cond_ok = !nzcv_q[2];
            4'h2: cond_ok = nzcv_q[1];
            4'h3: cond_ok = !nzcv_q[1];
            4'h4: cond_ok = nzcv_q[3];
            4'h5: cond_ok = !nzcv_q[3];
            4'h6: cond_ok = nzcv_q[0];
            4'h7: cond_ok = !nzcv_q[0];
            4'h8: cond_ok = nzcv_q[1] && !nzcv_q[2];
            4'h9: cond_ok = !nzcv_q[1] || nzcv_q[2];
            4'hA: cond_ok = (nzcv_q[3] == nzcv_q[0]);
            4'hB: cond_ok = (nzcv_q[3] != nzcv_q[0]);
            4'hC: cond_ok = !nzcv_q[2] && (nzcv_q[3] == nzcv_q[0]);
            4'hD: cond_ok = nzcv_q[2] || (nzcv_q[3] != nzcv_q[0]);
            default: cond_ok = 1'b1;
        endcase
    end

    assign wb_is_alu = (op_q == OP_MOV_LAS) || (op_q == OP_ADD) || (op_q == OP_ADC);

    // Handshake: a word transfers on a rising edge where instr_valid && instr_ready; ready is
    // high only in IDLE (and never during reset), so valid held high while busy is ignored.
    always_comb begin
        state_d         = state_q;
        bus.instr_ready = 1'b0;
        bus.cu_execute  = 1'b0;
        bus.rd_we       = 1'b0;
        bus.pc_we       = 1'b0;
        bus.cond_skip   = 1'b0;
        bus.undef       = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    bus.instr_ready = 1'b1;
                    if (bus.instr_valid) state_d = S_DECODE;
                end
                S_DECODE: begin
                    if (dec_undef) begin
                        bus.undef = 1'b1;
                        state_d   = S_IDLE;
                    end else if (!cond_ok) begin
                        bus.cond_skip = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        state_d = S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    bus.cu_execute = 1'b1;
                    state_d        = S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    bus.rd_we = wb_is_alu;
                    bus.pc_we = !wb_is_alu;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst)                                       instr_q <= '0;
        else if (state_q == S_IDLE && bus.instr_valid) instr_q <= bus.instr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= '0;
            rn_q          <= '0;
            rm_q          <= '0;
            rd_q          <= '0;
            rs_q          <= '0;
            imm_en_q      <= 1'b0;
            s_en_q        <= 1'b0;
            br_l_q        <= 1'b0;
            stype_q       <= '0;
            imm_shift_q   <= '0;
            imm_operand_q <= '0;
            br_offset_q   <= '0;
        end else if (state_q == S_DECODE) begin
            op_q          <= dec_op;
            rn_q          <= instr_q[19:16];
            rm_q          <= instr_q[3:0];
            rd_q          <= instr_q[15:12];
            rs_q          <= instr_q[11:8];
            imm_en_q      <= instr_q[25];
            s_en_q        <= instr_q[20];
            br_l_q        <= instr_q[24];
            stype_q       <= instr_q[6:5];
            imm_shift_q   <= instr_q[11:7];
            imm_operand_q <= instr_q[11:0];
            br_offset_q   <= instr_q[23:0];
        end
    end

    // MOV leaves V alone; ADD/ADC take all four ALU flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            nzcv_q <= FLAG_RST;
        end else if (state_q == S_WRITEBACK && wb_is_alu && s_en_q) begin
            nzcv_q[3:1] <= {bus.alu_n, bus.alu_z, bus.alu_c};
            if (op_q != OP_MOV_LAS) nzcv_q[0] <= bus.alu_v;
        end
    end

    assign bus.alu_op        = op_q;
    assign bus.rn_addr       = rn_q;
    assign bus.rm_addr       = rm_q;
    assign bus.rd_addr       = rd_q;
    assign bus.rs_addr       = rs_q;
    assign bus.imm_en        = imm_en_q;
    assign bus.s_en          = s_en_q;
    assign bus.br_l          = br_l_q;
    assign bus.stype         = stype_q;
    assign bus.imm_shift     = imm_shift_q;
    assign bus.imm_operand   = imm_operand_q;
    assign bus.br_offset_imm = br_offset_q;
    assign bus.flag_n        = nzcv_q[3];
    assign bus.flag_z        = nzcv_q[2];
    assign bus.flag_c        = nzcv_q[1];
    assign bus.flag_v        = nzcv_q[0];
    assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_exec_control_unit.sv
// Bench for exec_control_unit: directed scenarios plus randomized instruction streams checked
// against an instruction-level model of decode, condition evaluation, timing and flag updates.
module tb_exec_control_unit;

  localparam logic [3:0] FLAG_RST = 4'b0000;
  localparam logic [4:0] UNDEF_OP = 5'h1F;
  localparam logic [4:0] OP_MOV   = 5'h0D;
  localparam logic [4:0] OP_ADD   = 5'h04;
  localparam logic [4:0] OP_ADC   = 5'h05;
  localparam logic [4:0] OP_B     = 5'h10;
  localparam logic [4:0] OP_BX    = 5'h11;
  localparam logic [4:0] OP_ERET  = 5'h12;

  typedef struct {
    int exe_cyc; int wb_cyc; int skip_cyc; int undef_cyc; int rdy_cyc;
    int exe_cnt; int rd_cnt; int pc_cnt; int both;
    logic [4:0] op; logic [3:0] nzcv; logic [61:0] fields;
  } obs_t;

  logic clk;
  logic rst;
  int checks;
  int errors;
  logic [3:0] model_nzcv;
  logic [31:0] exp_q[$];

  exec_control_unit_if bus();

  exec_control_unit #(
    .FLAG_RST(FLAG_RST), .UNDEF_CODE(UNDEF_OP), .OP_MOV_LAS(OP_MOV), .OP_ADD(OP_ADD),
    .OP_ADC(OP_ADC), .OP_B(OP_B), .OP_BX(OP_BX), .OP_ERET(OP_ERET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // reference model
  function automatic int ref_kind(input logic [31:0] w);
    if (w[27:4] == 24'h12FFF1) return 4;
    if (w[27:0] == 28'h160006E) return 5;
    if (w[27:25] == 3'b101) return 3;
    if (w[27:26] == 2'b00) begin
      if (w[24:21] == 4'b1101) return 0;
      if (w[24:21] == 4'b0100) return 1;
      if (w[24:21] == 4'b0101) return 2;
    end
    return 6;
  endfunction

  function automatic logic [4:0] kind_op(input int k);
    case (k)
      0: return OP_MOV;
      1: return OP_ADD;
      2: return OP_ADC;
      3: return OP_B;
      4: return OP_BX;
      5: return OP_ERET;
      default: return UNDEF_OP;
    endcase
  endfunction

  function automatic bit cond_pass(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [61:0] exp_fields(input logic [31:0] w);
    return {w[19:16], w[3:0], w[15:12], w[11:8], w[25], w[20], w[24], w[6:5], w[11:7],
            w[11:0], w[23:0]};
  endfunction

  function automatic logic [61:0] obs_fields();
    return {bus.rn_addr, bus.rm_addr, bus.rd_addr, bus.rs_addr, bus.imm_en, bus.s_en, bus.br_l,
            bus.stype, bus.imm_shift, bus.imm_operand, bus.br_offset_imm};
  endfunction

  function automatic logic [31:0] pack_obs(input obs_t o);
    logic [2:0] rdy, exe, wb;
    logic [1:0] sk, ud, ec, rc, pc;
    rdy = o.rdy_cyc[2:0]; exe = o.exe_cyc[2:0]; wb = o.wb_cyc[2:0];
    sk = o.skip_cyc[1:0]; ud = o.undef_cyc[1:0];
    ec = o.exe_cnt[1:0]; rc = o.rd_cnt[1:0]; pc = o.pc_cnt[1:0];
    return {o.op, o.nzcv, rdy, exe, wb, sk, ud, ec, rc, pc, o.both[0], 3'b000};
  endfunction

  // Expected outcome of one instruction; advances the model flags.
  function automatic logic [31:0] model_step(input logic [31:0] w, input logic [3:0] alu_f);
    obs_t e;
    int k;
    e = '{default: 0};
    k = ref_kind(w);
    e.op = kind_op(k);
    if (k == 6) begin
      e.undef_cyc = 1; e.rdy_cyc = 2;
    end else if (!cond_pass(w[31:28], model_nzcv)) begin
      e.skip_cyc = 1; e.rdy_cyc = 2;
    end else begin
      e.exe_cyc = 2; e.wb_cyc = 3; e.rdy_cyc = 4; e.exe_cnt = 1;
      if (k <= 2) begin
        e.rd_cnt = 1;
        if (w[20]) begin
          model_nzcv[3:1] = alu_f[3:1];
          if (k != 0) model_nzcv[0] = alu_f[0];
        end
      end else begin
        e.pc_cnt = 1;
      end
    end
    e.nzcv = model_nzcv;
    return pack_obs(e);
  endfunction

  // driver: called at a falling edge, returns at the falling edge where ready reappears
  task automatic send_instr(input logic [31:0] word, input logic [3:0] alu_f, input bit hold,
                            output obs_t o);
    int w;
    w = 0;
    o = '{default: 0};
    while (!bus.instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.instr_ready) begin
      checks++; errors++;
      $display("FAIL accept_wait ready=%0b required=1", bus.instr_ready);
    end
    bus.instr_valid = 1'b1;
    bus.instr_word = word;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = alu_f;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.cu_execute) begin o.exe_cnt++; if (o.exe_cyc == 0) o.exe_cyc = c; end
      if (bus.rd_we) o.rd_cnt++;
      if (bus.pc_we) o.pc_cnt++;
      if ((bus.rd_we || bus.pc_we) && o.wb_cyc == 0) o.wb_cyc = c;
      if (bus.cond_skip && o.skip_cyc == 0) o.skip_cyc = c;
      if (bus.undef && o.undef_cyc == 0) o.undef_cyc = c;
      if (bus.cond_skip && bus.undef) o.both = 1;
      if (!hold) begin
        bus.instr_valid = 1'b0;
        bus.instr_word = $urandom;
      end
      if (bus.instr_ready) begin
        o.rdy_cyc = c;
        o.op = bus.alu_op;
        o.nzcv = {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
        o.fields = obs_fields();
        break;
      end
    end
    bus.instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_word = '0;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.instr_ready, bus.cu_execute, bus.rd_we, bus.pc_we, bus.cond_skip, bus.undef} !== 6'b0) begin
      errors++;
      $display("FAIL reset_held_outputs actual=%b required=000000",
               {bus.instr_ready, bus.cu_execute, bus.rd_we, bus.pc_we, bus.cond_skip, bus.undef});
    end
    rst = 1'b0;
    @(negedge clk);
    model_nzcv = FLAG_RST;
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready actual=%b required=1", bus.instr_ready);
    end
    checks++;
    if ({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v} !== FLAG_RST) begin
      errors++;
      $display("FAIL reset_flags actual=%b required=%b",
               {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}, FLAG_RST);
    end
    checks++;
    if ({bus.alu_op, obs_fields()} !== 67'd0) begin
      errors++; $display("FAIL reset_fields actual=%h required=0", {bus.alu_op, obs_fields()});
    end
  endtask

  task automatic test_mov();
    obs_t o;
    logic [31:0] e;
    e = model_step(32'hE3A01005, 4'b1111);
    send_instr(32'hE3A01005, 4'b1111, 1'b0, o);
    checks++;
    if (pack_obs(o) !== e) begin
      errors++; $display("FAIL mov_summary actual=%h required=%h", pack_obs(o), e);
    end
    checks++;
    if ({o.op, o.fields[45], o.fields[53:50], o.fields[35:24]} !== {OP_MOV, 1'b1, 4'd1, 12'h005}) begin
      errors++;
      $display("FAIL mov_fields actual=%h required=%h",
               {o.op, o.fields[45], o.fields[53:50], o.fields[35:24]}, {OP_MOV, 1'b1, 4'd1, 12'h005});
    end
    checks++;
    if ({o.exe_cyc[2:0], o.wb_cyc[2:0], o.rdy_cyc[2:0], o.rd_cnt[1:0]} !== {3'd2, 3'd3, 3'd4, 2'd1}) begin
      errors++;
      $display("FAIL mov_latency actual=exe%0d wb%0d rdy%0d rd%0d required=exe2 wb3 rdy4 rd1",
               o.exe_cyc, o.wb_cyc, o.rdy_cyc, o.rd_cnt);
    end
  endtask

  task automatic test_adds();
    obs_t o;
    logic [31:0] e;
    e = model_step(32'hE0921003, 4'b0110);
    send_instr(32'hE0921003, 4'b0110, 1'b0, o);
    checks++;
    if (pack_obs(o) !== e) begin
      errors++; $display("FAIL adds_summary actual=%h required=%h", pack_obs(o), e);
    end
    checks++;
    if (o.nzcv !== 4'b0110) begin
      errors++; $display("FAIL adds_flags actual=%b required=0110", o.nzcv);
    end
    checks++;
    if (o.fields[61:50] !== 12'h231) begin
      errors++; $display("FAIL adds_regs actual=%h required=231", o.fields[61:50]);
    end
  endtask

  task automatic test_cond_skip();
    obs_t o;
    logic [31:0] e;
    e = model_step(32'hE0921003, 4'b0000);
    send_instr(32'hE0921003, 4'b0000, 1'b0, o);
    checks++;
    if (pack_obs(o) !== e) begin
      errors++; $display("FAIL clearz_summary actual=%h required=%h", pack_obs(o), e);
    end
    e = model_step(32'h00821003, 4'b1111);
    send_instr(32'h00821003, 4'b1111, 1'b0, o);
    checks++;
    if (pack_obs(o) !== e) begin
      errors++; $display("FAIL addeq_summary actual=%h required=%h", pack_obs(o), e);
    end
    checks++;
    if ({o.skip_cyc[1:0], o.exe_cnt[1:0], o.rd_cnt[1:0], o.rdy_cyc[2:0], o.nzcv} !==
        {2'd1, 2'd0, 2'd0, 3'd2, 4'b0000}) begin
      errors++;
      $display("FAIL addeq_skip actual=skip%0d exe%0d rd%0d rdy%0d nzcv%b required=skip1 exe0 rd0 rdy2 nzcv0000",
               o.skip_cyc, o.exe_cnt, o.rd_cnt, o.rdy_cyc, o.nzcv);
    end
  endtask

  task automatic test_branch();
    obs_t o;
    logic [31:0] e;
    e = model_step(32'hEB000010, 4'b1111);
    send_instr(32'hEB000010, 4'b1111, 1'b0, o);
    checks++;
    if (pack_obs(o) !== e) begin
      errors++; $display("FAIL bl_summary actual=%h required=%h", pack_obs(o), e);
    end
    checks++;
    if ({o.op, o.fields[43], o.fields[23:0], o.pc_cnt[1:0], o.rd_cnt[1:0]} !==
        {OP_B, 1'b1, 24'h000010, 2'd1, 2'd0}) begin
      errors++;
      $display("FAIL bl_fields actual=op%h l%b off%h pc%0d rd%0d required=op%h l1 off000010 pc1 rd0",
               o.op, o.fields[43], o.fields[23:0], o.pc_cnt, o.rd_cnt, OP_B);
    end
    e = model_step(32'hE12FFF1E, 4'b1111);
    send_instr(32'hE12FFF1E, 4'b1111, 1'b0, o);
    checks++;
    if ({o.op, o.fields[57:54]} !== {OP_BX, 4'hE} || pack_obs(o) !== e) begin
      errors++;
      $display("FAIL bx_decode actual=%h/%h required=%h/%h", {o.op, o.fields[57:54]},
               pack_obs(o), {OP_BX, 4'hE}, e);
    end
    e = model_step(32'hE160006E, 4'b1111);
    send_instr(32'hE160006E, 4'b1111, 1'b0, o);
    checks++;
    if (pack_obs(o) !== e) begin
      errors++; $display("FAIL eret_summary actual=%h required=%h", pack_obs(o), e);
    end
    // Branch with bit 20 set must not touch the flags.
    e = model_step(32'hEA100000, 4'b1111);
    send_instr(32'hEA100000, 4'b1111, 1'b0, o);
    checks++;
    if (pack_obs(o) !== e) begin
      errors++; $display("FAIL b_sbit_summary actual=%h required=%h", pack_obs(o), e);
    end
  endtask

  task automatic test_undef();
    obs_t o;
    logic [31:0] e;
    e = model_step(32'hE7F000F0, 4'b1111);
    send_instr(32'hE7F000F0, 4'b1111, 1'b1, o);
    checks++;
    if (pack_obs(o) !== e) begin
      errors++; $display("FAIL undef_summary actual=%h required=%h", pack_obs(o), e);
    end
    checks++;
    if ({o.undef_cyc[1:0], o.op, o.exe_cnt[1:0], o.both[0]} !== {2'd1, UNDEF_OP, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL undef_pulse actual=u%0d op%h exe%0d both%0d required=u1 op1f exe0 both0",
               o.undef_cyc, o.op, o.exe_cnt, o.both);
    end
    e = model_step(32'hE3A02007, 4'b0000);
    send_instr(32'hE3A02007, 4'b0000, 1'b1, o);
    checks++;
    if (pack_obs(o) !== e) begin
      errors++; $display("FAIL hold_valid_summary actual=%h required=%h", pack_obs(o), e);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic [31:0] e;
    e = model_step(32'hE0921003, 4'b1111);
    send_instr(32'hE0921003, 4'b1111, 1'b0, o);
    checks++;
    if (o.nzcv !== 4'b1111 || pack_obs(o) !== e) begin
      errors++; $display("FAIL preset_flags actual=%h required=%h", pack_obs(o), e);
    end
    bus.instr_valid = 1'b1;
    bus.instr_word = 32'hE3B01005;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = 4'b1010;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cu_execute !== 1'b1) begin
      errors++; $display("FAIL mid_in_execute actual=%b required=1", bus.cu_execute);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.cu_execute !== 1'b0) begin
      errors++; $display("FAIL mid_rst_execute actual=%b required=0", bus.cu_execute);
    end
    @(negedge clk);
    checks++;
    if ({bus.rd_we, bus.pc_we, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v} !== {2'b00, FLAG_RST}) begin
      errors++;
      $display("FAIL mid_rst_wb actual=%b required=%b",
               {bus.rd_we, bus.pc_we, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}, {2'b00, FLAG_RST});
    end
    rst = 1'b0;
    model_nzcv = FLAG_RST;
    @(negedge clk);
    checks++;
    if ({bus.instr_ready, bus.alu_op} !== {1'b1, 5'd0}) begin
      errors++; $display("FAIL mid_rst_ready actual=%h required=%h", {bus.instr_ready, bus.alu_op}, 6'h20);
    end
    e = model_step(32'hE3B03009, 4'b1100);
    send_instr(32'hE3B03009, 4'b1100, 1'b0, o);
    checks++;
    if (pack_obs(o) !== e) begin
      errors++; $display("FAIL after_rst_summary actual=%h required=%h", pack_obs(o), e);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [31:0] words[6];
    logic [31:0] e;
    int t0;
    words = '{32'hE3B01000, 32'hE0B21003, 32'h10821003, 32'hEB000020, 32'hE7F000F0, 32'hE2942001};
    t0 = $time;
    foreach (words[i]) begin
      e = model_step(words[i], 4'b0101);
      send_instr(words[i], 4'b0101, 1'b0, o);
      checks++;
      if (pack_obs(o) !== e) begin
        errors++; $display("FAIL b2b_%0d actual=%h required=%h", i, pack_obs(o), e);
      end
    end
    // Four full instructions at 4 cycles each plus one skip/undef pair... computed by the model
    checks++;
    if (($time - t0) / 10 !== 64'd20) begin
      errors++; $display("FAIL b2b_throughput actual=%0d required=20 cycles", ($time - t0) / 10);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [31:0] w;
    logic [31:0] got;
    logic [31:0] e;
    logic [3:0] f;
    logic [3:0] ops[4];
    ops = '{4'b1101, 4'b0100, 4'b0101, 4'b0000};
    for (int n = 0; n < 200; n++) begin
      w = $urandom;
      case ($urandom_range(0, 5))
        0: begin
          w[27:26] = 2'b00;
          ops[3] = 4'($urandom_range(0, 15));
          w[24:21] = ops[$urandom_range(0, 3)];
        end
        1: w[27:25] = 3'b101;
        2: w[27:4] = 24'h12FFF1;
        3: w[27:0] = 28'h160006E;
        default: ;
      endcase
      f = 4'($urandom_range(0, 15));
      exp_q.push_back(model_step(w, f));
      send_instr(w, f, 1'($urandom_range(0, 1)), o);
      got = pack_obs(o);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL rand_%0d word=%h actual=%h required=%h", n, w, got, e);
      end
      checks++;
      if (o.fields !== exp_fields(w)) begin
        errors++; $display("FAIL rand_fields_%0d actual=%h required=%h", n, o.fields, exp_fields(w));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_nzcv = FLAG_RST;
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_word = '0;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = 4'b0000;
    test_reset();
    test_mov();
    test_adds();
    test_cond_skip();
    test_branch();
    test_undef();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
